// File: rtl/score_timer.sv
// score_timer -- countdown timer plus score keeper for a whack-a-mole game.
//
// A round lasts TIME_TENS:TIME_ONES seconds (two BCD digits). A start event
// begins a round; every tick counts the timer down and hit/miss events move
// the score up/down. When the timer reaches 00 the game is over and the
// result stays frozen until the next start event.
//
// Ports:
//   clk        system clock, all state on its rising edge
//   rst        synchronous active-high reset
//   tick       one-cycle pulse, once per second
//   start      debounced start button level (rising edge = event)
//   hit        debounced correct-whack level (rising edge = event)
//   miss       debounced wrong-whack level (rising edge = event)
//   digit_1    BCD timer tens
//   digit_2    BCD timer ones
//   digit_3    BCD score tens
//   digit_4    BCD score ones
//   running    high while a round is in progress
//   game_over  high once a round has ended
module score_timer #(
  parameter logic [3:0] TIME_TENS = 4'd6,
  parameter logic [3:0] TIME_ONES = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       start,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2,
  output logic [3:0] digit_3,
  output logic [3:0] digit_4,
  output logic       running,
  output logic       game_over
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  // A zero-length round ends the moment it begins.
  localparam logic ZERO_ROUND = (TIME_TENS == 4'd0) && (TIME_ONES == 4'd0);

  state_t     state;
  state_t     state_next;

  logic       start_q;
  logic       hit_q;
  logic       miss_q;
  logic       start_ev;
  logic       hit_ev;
  logic       miss_ev;

  logic [7:0] timer_next;
  logic [7:0] score_next;

  // Two-digit BCD increment, saturating at 99.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v != 8'h99) begin
      if (v[3:0] == 4'd9) begin
        r[7:4] = v[7:4] + 4'd1;
        r[3:0] = 4'd0;
      end else begin
        r[3:0] = v[3:0] + 4'd1;
      end
    end
    return r;
  endfunction

  // Two-digit BCD decrement, saturating at 00.
  function automatic logic [7:0] bcd_dec(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v != 8'h00) begin
      if (v[3:0] == 4'd0) begin
        r[7:4] = v[7:4] - 4'd1;
        r[3:0] = 4'd9;
      end else begin
        r[3:0] = v[3:0] - 4'd1;
      end
    end
    return r;
  endfunction

  // Events fire only on a 0->1 change between consecutive samples; history is
  // cleared by reset so a level already high afterwards still counts once.
  assign start_ev = start & ~start_q;
  assign hit_ev   = hit   & ~hit_q;
  assign miss_ev  = miss  & ~miss_q;

  always_comb begin
    state_next = state;
    timer_next = {digit_1, digit_2};
    score_next = {digit_3, digit_4};
    case (state)
      IDLE, OVER: begin
        if (start_ev) begin
          timer_next = {TIME_TENS, TIME_ONES};
          score_next = '0;
          state_next = ZERO_ROUND ? OVER : RUN;
        end
      end
      RUN: begin
        // Simultaneous hit and miss cancel each other.
        if (hit_ev && !miss_ev) begin
          score_next = bcd_inc({digit_3, digit_4});
        end else if (miss_ev && !hit_ev) begin
          score_next = bcd_dec({digit_3, digit_4});
        end
        if (tick) begin
          timer_next = bcd_dec({digit_1, digit_2});
          if (timer_next == 8'h00) begin
            state_next = OVER;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      start_q   <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      digit_1   <= TIME_TENS;
      digit_2   <= TIME_ONES;
      digit_3   <= '0;
      digit_4   <= '0;
      running   <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_next;
      start_q   <= start;
      hit_q     <= hit;
      miss_q    <= miss;
      digit_1   <= timer_next[7:4];
      digit_2   <= timer_next[3:0];
      digit_3   <= score_next[7:4];
      digit_4   <= score_next[3:0];
      running   <= (state_next == RUN);
      game_over <= (state_next == OVER);
    end
  end

endmodule

// File: doc/score_timer.md
SCORE_TIMER -- requirements
Module: score_timer

Interface
REQ-001 Parameter TIME_TENS, default 6, BCD tens digit of round length in seconds (legal 0..9).
REQ-002 Parameter TIME_ONES, default 0, BCD ones digit of round length in seconds (legal 0..9).
REQ-003 clk  input  1  system clock; single clock domain, all state on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 tick  input  1  one-cycle pulse, once per second, synchronous to clk.
REQ-006 start  input  1  debounced start button level.
REQ-007 hit  input  1  debounced level, high while a correct mole whack is registered.
REQ-008 miss  input  1  debounced level, high while a wrong or empty whack is registered.
REQ-009 digit_1  output  4  BCD timer tens (leftmost display digit).
REQ-010 digit_2  output  4  BCD timer ones.
REQ-011 digit_3  output  4  BCD score tens.
REQ-012 digit_4  output  4  BCD score ones (rightmost display digit).
REQ-013 running  output  1  high in RUN state.
REQ-014 game_over  output  1  high in OVER state.

Function
REQ-015 Block SHALL implement FSM with states IDLE, RUN, OVER.
REQ-016 start, hit and miss SHALL each be rising-edge detected; only a 0->1 transition between consecutive clk samples is an event; a held level produces exactly one event.
REQ-017 IDLE: timer digits show TIME_TENS/TIME_ONES, score 00; start event -> RUN next cycle; hit/miss/tick ignored.
REQ-018 RUN: each tick decrements timer as two-digit BCD (x0 -> (x-1)9; 10 -> 09; 01 -> 00).
REQ-019 RUN: tick that takes timer from 01 to 00 SHALL move FSM to OVER in the same update; timer shows 00.
REQ-020 RUN: hit event increments score as two-digit BCD (x9 -> (x+1)0), saturating at 99.
REQ-021 RUN: miss event decrements score as two-digit BCD (x0 -> (x-1)9), saturating at 00.
REQ-022 Same-cycle hit and miss events in RUN SHALL cancel (score unchanged).
REQ-023 Same-cycle tick and hit/miss in RUN SHALL both apply, including on the final tick (score updated, then OVER).
REQ-024 start event in RUN SHALL be ignored.
REQ-025 OVER: timer and score frozen; hit/miss/tick ignored; start event -> RUN with timer reloaded from parameters and score cleared to 00, all in one cycle.
REQ-026 If parameters give 00, a start event SHALL go directly to OVER with timer 00, score 00.
REQ-027 All outputs SHALL be registered; digits reflect an event on the clk edge after the event is detected (1-cycle latency from edge-detected input sample).
REQ-028 Digit outputs SHALL never carry values 10..15.
REQ-029 running and game_over SHALL never be high simultaneously.

Reset
REQ-030 rst high SHALL, on next posedge clk, force IDLE, digit_1=TIME_TENS, digit_2=TIME_ONES, digit_3=0, digit_4=0, running=0, game_over=0, and clear edge-detector history to 0.
REQ-031 rst SHALL take priority over all other inputs in any state, including mid-round.
REQ-032 A start/hit/miss level already high when rst deasserts SHALL register as an event on the first cycle after reset (history cleared to 0).

Verification
REQ-033 Reset, start pulse, 60 ticks -> timer 60,59..10,09..00; running drops and game_over rises on 60th tick; 59->..->00 BCD-correct.
REQ-034 In RUN, 101 hit events -> score 01..99 then holds 99; one miss -> 98; miss from 00 -> stays 00.
REQ-035 hit held high 50 cycles -> score +1 only; hit and miss rising same cycle -> score unchanged.
REQ-036 Timer at 01, tick and hit same cycle, score 09 -> timer 00, score 10, game_over=1; later hits ignored.
REQ-037 In OVER with score 42, start -> timer 60, score 00, running=1 next cycle; start during RUN -> no change.
REQ-038 rst asserted mid-round (timer 37, score 15) -> next cycle IDLE, digits 6,0,0,0, running=0, game_over=0.
